// File: rtl/sd_emmc_iddr_deser_if.sv
// Handshake/data bundle for sd_emmc_iddr_deser: DAT lines and control in, assembled words and status out.
interface sd_emmc_iddr_deser_if #(
    parameter int DATA_W = 8,
    parameter int WORD_W = 32
);
    logic [DATA_W-1:0] in_data;
    logic              arm;
    logic              ddr_mode;
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;
    logic              busy;
    logic              done;
    logic              overflow;
    logic              timeout;

    modport master (
        output in_data, arm, ddr_mode, word_ready,
        input  word_data, word_valid, busy, done, overflow, timeout
    );

    modport slave (
        input  in_data, arm, ddr_mode, word_ready,
        output word_data, word_valid, busy, done, overflow, timeout
    );
endinterface

// File: rtl/sd_emmc_iddr_deser.sv
// eMMC DAT-line block receiver: SDR/DDR capture, word assembly (MSB first), one-entry output buffer.
// Define SD_EMMC_IDDR_TIMEOUT_EN to enable the start-bit timeout (TIMEOUT_CYC clocks).
module sd_emmc_iddr_deser #(
    parameter int DATA_W      = 8,
    parameter int WORD_W      = 32,
    parameter int BLK_BYTES   = 512,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clock,
    input  logic                reset_n,
    sd_emmc_iddr_deser_if.slave io
);
    localparam int BLK_BITS = BLK_BYTES * 8;
    localparam int CNT_W    = $clog2(BLK_BITS + 1);
    localparam logic [CNT_W-1:0] BLK_C  = CNT_W'(BLK_BITS);
    localparam logic [CNT_W-1:0] WORD_C = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] STEP_S = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] STEP_D = CNT_W'(2 * DATA_W);

    if ((WORD_W % (2 * DATA_W)) != 0 || (BLK_BITS % WORD_W) != 0 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("sd_emmc_iddr_deser: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, WAIT_START, CAPTURE, DONE} state_t;
    state_t state, nxt;

    logic              ddr_q, pair_vld;
    logic [DATA_W-1:0] rise_q, fall_q;
    logic [WORD_W-1:0] asm_q, asm_nxt, word_q;
    logic [CNT_W-1:0]  bit_cnt, wbit_cnt, step;
    logic              vld_q, ovf_q;
    logic              arm_go, start_bit, shift_en, word_done, last;

    assign start_bit = (io.in_data == '0);
    assign arm_go    = (state == IDLE) && io.arm;
    // DDR shifts one cycle late: the pair needs the falling sample that follows the rising one.
    assign shift_en  = (state == CAPTURE) && (!ddr_q || pair_vld);
    assign word_done = shift_en && ((wbit_cnt + step) == WORD_C);
    assign last      = shift_en && ((bit_cnt + step) == BLK_C);

    always_comb begin
        step    = ddr_q ? STEP_D : STEP_S;
        asm_nxt = ddr_q ? ((asm_q << (2 * DATA_W)) | WORD_W'({rise_q, fall_q}))
                        : ((asm_q << DATA_W) | WORD_W'(io.in_data));
    end

`ifdef SD_EMMC_IDDR_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_q, tmo_hit;

    assign tmo_hit = (state == WAIT_START) && !start_bit && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
            tmo_q   <= 1'b0;
        end else begin
            tmo_q   <= tmo_hit;
            tmo_cnt <= (state == WAIT_START) ? tmo_cnt + 1'b1 : '0;
        end
    end

    assign io.timeout = tmo_q;
`else
    assign io.timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:       if (io.arm) nxt = WAIT_START;
            WAIT_START: begin
                if (start_bit) nxt = CAPTURE;
`ifdef SD_EMMC_IDDR_TIMEOUT_EN
                else if (tmo_hit) nxt = IDLE;
`endif
            end
            CAPTURE:    if (last) nxt = DONE;
            DONE:       nxt = IDLE;
            default:    nxt = IDLE;
        endcase
    end

    always_comb begin
        io.busy = (state != IDLE);
        io.done = (state == DONE);
    end

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) fall_q <= '0;
        else          fall_q <= io.in_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ddr_q    <= 1'b0;
            pair_vld <= 1'b0;
            rise_q   <= '0;
            asm_q    <= '0;
            bit_cnt  <= '0;
            wbit_cnt <= '0;
        end else begin
            rise_q   <= io.in_data;
            pair_vld <= (state == CAPTURE);
            if (arm_go) begin
                ddr_q    <= io.ddr_mode;
                asm_q    <= '0;
                bit_cnt  <= '0;
                wbit_cnt <= '0;
            end else if (shift_en) begin
                asm_q    <= asm_nxt;
                bit_cnt  <= bit_cnt + step;
                wbit_cnt <= word_done ? '0 : wbit_cnt + step;
            end
        end
    end

    // A finished word is dropped, never stalls capture, when the held word is not being taken.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word_q <= '0;
            vld_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (word_done) begin
                if (!vld_q || io.word_ready) begin
                    word_q <= asm_nxt;
                    vld_q  <= 1'b1;
                end else begin
                    ovf_q  <= 1'b1;
                end
            end else if (vld_q && io.word_ready) begin
                vld_q <= 1'b0;
            end
            if (arm_go) ovf_q <= 1'b0;
        end
    end

    assign io.word_data  = word_q;
    assign io.word_valid = vld_q;
    assign io.overflow   = ovf_q;
endmodule

// File: doc/sd_emmc_iddr_deser.md
SD_EMMC_IDDR_DESER -- requirements
Module: sd_emmc_iddr_deser

Interface
REQ-001 Parameter DATA_W, default 8, eMMC data-bus width in lines (1, 4 or 8).
REQ-002 Parameter WORD_W, default 32, output word width; SHALL be a multiple of 2*DATA_W.
REQ-003 Parameter BLK_BYTES, default 512, data bytes per block; BLK_BYTES*8 SHALL be a multiple of WORD_W.
REQ-004 Parameter TIMEOUT_CYC, default 1024, start-bit wait limit in clocks; used only under the configuration macro.
REQ-005 clock  input  1  single clock; both edges are used for capture.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 in_data  input  DATA_W  eMMC DAT lines.
REQ-008 arm  input  1  one-cycle pulse that starts one block receive; honoured only in IDLE.
REQ-009 ddr_mode  input  1  1 = DDR capture (both edges), 0 = SDR capture (rising edge only); sampled on arm.
REQ-010 word_data  output  WORD_W  assembled word; the first-received bits are in the MSBs.
REQ-011 word_valid  output  1  word_data holds an unread word.
REQ-012 word_ready  input  1  consumer accepts the word when word_valid and word_ready are both 1 at a rising edge.
REQ-013 busy  output  1  high in every state other than IDLE.
REQ-014 done  output  1  one-cycle pulse after the last word of the block is produced.
REQ-015 overflow  output  1  sticky flag: a word was dropped.
REQ-016 timeout  output  1  one-cycle pulse on start-bit timeout (macro only; otherwise tied 0).

Function
REQ-017 States: IDLE, WAIT_START, CAPTURE, DONE.
REQ-018 IDLE -> WAIT_START on arm. The arm edge also latches ddr_mode, clears overflow and clears the bit counter.
REQ-019 In WAIT_START, a rising edge sampling in_data == 0 on all lines is the start bit; the FSM moves to CAPTURE on the next cycle.
REQ-020 CAPTURE, SDR mode: each rising edge shifts DATA_W bits into the assembly register, with new bits entering at the LSBs.
REQ-021 CAPTURE, DDR mode: a rising-edge register and a falling-edge register each sample in_data.
REQ-022 DDR pairing: at each rising edge, the pair {rising sample of cycle k, falling sample between k and k+1} is shifted in (2*DATA_W bits, rising sample first). The first pair uses the first rising edge after the start-bit cycle.
REQ-023 When WORD_W bits have accumulated, the word loads the output buffer and word_valid sets on the following rising edge. The assembly register continues without a stall.
REQ-024 Output buffer is one entry. word_valid clears on accept unless a new word loads in the same cycle, in which case word_valid stays 1 with the new data.
REQ-025 If a new word completes while word_valid=1 and word_ready=0, the new word is dropped, the held word is kept, and overflow sets.
REQ-026 After BLK_BYTES*8 bits are received, CAPTURE -> DONE. DONE asserts done for one cycle and then goes to IDLE. word_valid persists until the word is accepted.
REQ-027 CRC and end-bit checking are out of scope; bits after the block are ignored.
REQ-028 arm and ddr_mode changes while busy=1 have no effect.

Reset
REQ-029 reset_n low at any time (asynchronous) forces: FSM IDLE; word_data=0; word_valid=0; busy=0; done=0; overflow=0; timeout=0; counters and both edge registers cleared.
REQ-030 Reset asserted mid-block abandons the block, and no done pulse occurs.
REQ-031 Deassertion: the first active edge after reset_n rises is treated as a normal IDLE cycle.

Configuration
REQ-032 With macro SD_EMMC_IDDR_TIMEOUT_EN defined: a counter runs in WAIT_START. After TIMEOUT_CYC cycles with no start bit, the block pulses timeout for one cycle and returns to IDLE, with no words and no done.
REQ-033 Without SD_EMMC_IDDR_TIMEOUT_EN: WAIT_START waits indefinitely, no counter is instantiated, and timeout is constant 0.

Verification
REQ-034 DATA_W=8, SDR, word_ready=1, bytes 0x01,0x02,...: first word_data=0x01020304, 128 words, then done pulse.
REQ-035 DATA_W=8, DDR, rising bytes 0xA0,0xA2... and falling bytes 0xA1,0xA3...: first word=0xA0A1A2A3, 128 words over 256 capture cycles.
REQ-036 word_ready=0 held for 2 word times: first word is retained, second is dropped, overflow=1; the next arm clears overflow.
REQ-037 reset_n pulsed low at word 50 of a DDR block: all outputs are 0 at once, no done pulse; after re-arm, a full block is received correctly.
REQ-038 With SD_EMMC_IDDR_TIMEOUT_EN and TIMEOUT_CYC=16, arm with in_data held 0xFF: timeout pulses 16 cycles after WAIT_START entry and busy drops; without the macro, busy stays high.
REQ-039 DATA_W=1, SDR: 4096 bits yield 128 words. A second arm pulse mid-block is ignored, and exactly one done pulse occurs.
